// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    // Bits resolved by one carry-lookahead group.
    localparam int GROUP_W = 4;

    // Operation select encoding.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/cla4_group.sv
// Four-bit carry-lookahead group: sum bits plus group generate/propagate
// for the stage-level lookahead that feeds this group its carry-in.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] sum_o,
    output logic               gen_o,
    output logic               prop_o
);

    logic [GROUP_W-1:0] bitG;
    logic [GROUP_W-1:0] bitP;
    logic [GROUP_W-1:0] bitC;

    // Flat two-level lookahead for the internal carries, then sum and group G/P.
    always_comb begin
        bitG    = a_i & b_i;
        bitP    = a_i ^ b_i;
        bitC[0] = cin_i;
        bitC[1] = bitG[0] | (bitP[0] & cin_i);
        bitC[2] = bitG[1] | (bitP[1] & bitG[0]) | (bitP[1] & bitP[0] & cin_i);
        bitC[3] = bitG[2] | (bitP[2] & bitG[1]) | (bitP[2] & bitP[1] & bitG[0])
                | (bitP[2] & bitP[1] & bitP[0] & cin_i);
        sum_o   = bitP ^ bitC;
        gen_o   = bitG[3] | (bitP[3] & bitG[2]) | (bitP[3] & bitP[2] & bitG[1])
                | (bitP[3] & bitP[2] & bitP[1] & bitG[0]);
        prop_o  = &bitP;
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract built from 4-bit lookahead groups. Each stage
// resolves a contiguous slice of groups (LSB first) and hands the partial
// sum, the carry out of its slice and the operands on to the next stage.
// The last stage register doubles as the registered output. WIDTH must be a
// multiple of 4 (min 8) and WIDTH/4 must divide evenly by STAGES.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int GROUPS = WIDTH / GROUP_W;
    localparam int GPS    = GROUPS / STAGES;
    localparam int SW     = GPS * GROUP_W;

    // Per-stage pipeline registers
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  opA_q  [STAGES];
    logic [WIDTH-1:0]  opB_q  [STAGES];
    logic [WIDTH-1:0]  sum_q  [STAGES];
    logic [STAGES-1:0] carry_q;
    logic              ovf_q;
    logic              zero_q;

    // Per-stage combinational inputs and results
    logic [WIDTH-1:0]  srcA   [STAGES];
    logic [WIDTH-1:0]  srcB   [STAGES];
    logic [WIDTH-1:0]  srcSum [STAGES];
    logic [STAGES-1:0] srcCin;
    logic [WIDTH-1:0]  sum_d  [STAGES];
    logic [STAGES-1:0] stgCout;

    // Group-level signals
    logic [WIDTH-1:0]  grpSum;
    logic [GROUPS-1:0] grpG;
    logic [GROUPS-1:0] grpP;
    logic [GROUPS-1:0] grpCin;

    // Handshake
    logic [STAGES:0]   downReady;
    logic [STAGES-1:0] upValid;
    logic [STAGES-1:0] loadEn;

    logic              msbCarryIn;
    logic              ovf_d;
    logic              zero_d;

    // Stage 0 takes the raw operands (B inverted with carry-in 1 for subtract);
    // later stages take the previous stage's registers.
    always_comb begin
        srcA[0]   = a;
        srcB[0]   = (op == OP_SUB) ? ~b : b;
        srcSum[0] = '0;
        srcCin[0] = (op == OP_SUB);
        for (int s = 1; s < STAGES; s++) begin
            srcA[s]   = opA_q[s-1];
            srcB[s]   = opB_q[s-1];
            srcSum[s] = sum_q[s-1];
            srcCin[s] = carry_q[s-1];
        end
    end

    // One lookahead group per 4 bits; a group reads its owning stage's operands.
    for (genvar g = 0; g < GROUPS; g++) begin : gen_group
        localparam int S = g / GPS;
        cla4_group u_group (
            .a_i    (srcA[S][g*GROUP_W +: GROUP_W]),
            .b_i    (srcB[S][g*GROUP_W +: GROUP_W]),
            .cin_i  (grpCin[g]),
            .sum_o  (grpSum[g*GROUP_W +: GROUP_W]),
            .gen_o  (grpG[g]),
            .prop_o (grpP[g])
        );
    end

    // Carry into each group of a stage as a sum of G/P products back to the stage carry-in.
    always_comb begin
        logic cTerm;
        logic pTerm;
        int   base;
        grpCin  = '0;
        stgCout = '0;
        cTerm   = 1'b0;
        pTerm   = 1'b0;
        base    = 0;
        for (int s = 0; s < STAGES; s++) begin
            base = s * GPS;
            for (int j = 0; j <= GPS; j++) begin
                cTerm = srcCin[s];
                for (int i = 0; i < j; i++) begin
                    cTerm = cTerm & grpP[base+i];
                end
                for (int i = 0; i < j; i++) begin
                    pTerm = grpG[base+i];
                    for (int m = i + 1; m < j; m++) begin
                        pTerm = pTerm & grpP[base+m];
                    end
                    cTerm = cTerm | pTerm;
                end
                if (j < GPS) begin
                    grpCin[base+j] = cTerm;
                end else begin
                    stgCout[s] = cTerm;
                end
            end
        end
    end

    // Merge this stage's freshly resolved slice into the partial sum; derive final flags.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            sum_d[s]             = srcSum[s];
            sum_d[s][s*SW +: SW] = grpSum[s*SW +: SW];
        end
        msbCarryIn = sum_d[STAGES-1][WIDTH-1] ^ srcA[STAGES-1][WIDTH-1]
                   ^ srcB[STAGES-1][WIDTH-1];
        ovf_d      = msbCarryIn ^ stgCout[STAGES-1];
        zero_d     = (sum_d[STAGES-1] == '0);
    end

    // Ready ripples back from the consumer: a stage can load if empty or advancing.
    always_comb begin
        downReady[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            downReady[s] = !vld_q[s] || downReady[s+1];
        end
        upValid[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            upValid[s] = vld_q[s-1];
        end
        loadEn = downReady[STAGES-1:0] & upValid;
        for (int s = 0; s < STAGES; s++) begin
            vld_d[s] = downReady[s] ? upValid[s] : vld_q[s];
        end
    end

    assign in_ready = downReady[0] && !rst;

    // Pipeline registers; data only moves on a load so a stalled output holds steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                opA_q[s] <= '0;
                opB_q[s] <= '0;
                sum_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < STAGES; s++) begin
                if (loadEn[s]) begin
                    opA_q[s]   <= srcA[s];
                    opB_q[s]   <= srcB[s];
                    sum_q[s]   <= sum_d[s];
                    carry_q[s] <= stgCout[s];
                end
            end
            if (loadEn[STAGES-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign result    = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three instances (STAGES 1, 2, 8), a table of
// directed vectors, stall/reset sequences, and a random run against a model.
module tb_pipelined_cla_addsub;

    localparam int W    = 32;
    localparam int NDUT = 3;
    localparam int NRND = 1000;
    localparam int MEMD = 4096;

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
    } beat_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic         ez;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid  [NDUT];
    logic         inReady  [NDUT];
    logic [W-1:0] aIn      [NDUT];
    logic [W-1:0] bIn      [NDUT];
    logic         opIn     [NDUT];
    logic         outValid [NDUT];
    logic         outReady [NDUT];
    logic [W-1:0] res      [NDUT];
    logic         coutO    [NDUT];
    logic         ovfO     [NDUT];
    logic         zeroO    [NDUT];

    int    stgOf [NDUT] = '{1, 2, 8};
    beat_t expMem [NDUT][MEMD];
    int    head   [NDUT];
    int    tail   [NDUT];
    int    popCnt [NDUT];
    logic  accepted [NDUT];

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [10];

    for (genvar k = 0; k < NDUT; k++) begin : gen_dut
        localparam int STG = (k == 0) ? 1 : ((k == 1) ? 2 : 8);
        pipelined_cla_addsub #(.WIDTH(W), .STAGES(STG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (inValid[k]),
            .in_ready  (inReady[k]),
            .a         (aIn[k]),
            .b         (bIn[k]),
            .op        (opIn[k]),
            .out_valid (outValid[k]),
            .out_ready (outReady[k]),
            .result    (res[k]),
            .cout      (coutO[k]),
            .ovf       (ovfO[k]),
            .zero      (zeroO[k])
        );
    end

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s", name);
    endtask

    // Plain-arithmetic reference: wide unsigned sum/difference and signed range check.
    function automatic beat_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic op);
        beat_t  r;
        longint ua, ub, sa, sb, full, sfull;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            full   = ua - ub;
            sfull  = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            full   = ua + ub;
            sfull  = sa + sb;
            r.cout = (full > 64'sd4294967295);
        end
        r.result = W'(full);
        r.ovf    = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
        r.zero   = (r.result == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] randOperand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input int k, input logic v, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic op);
        inValid[k] = v;
        aIn[k]     = a;
        bIn[k]     = b;
        opIn[k]    = op;
    endtask

    // One clock: scoreboard every instance at the negedge, then step past the posedge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            accepted[k] = 1'b0;
            if (outValid[k]) begin
                if (head[k] < tail[k]) begin
                    e = expMem[k][head[k]];
                    checkOutput($sformatf("dut%0d result", k), res[k], e.result);
                    checkOutput($sformatf("dut%0d cout", k), coutO[k], e.cout);
                    checkOutput($sformatf("dut%0d ovf", k), ovfO[k], e.ovf);
                    checkOutput($sformatf("dut%0d zero", k), zeroO[k], e.zero);
                    if (outReady[k]) begin
                        head[k]++;
                        popCnt[k]++;
                    end
                end else begin
                    failNow($sformatf("dut%0d unexpected output beat 0x%0h", k, res[k]));
                end
            end
            if (inValid[k] && inReady[k]) begin
                if (tail[k] < MEMD) begin
                    expMem[k][tail[k]] = refModel(aIn[k], bIn[k], opIn[k]);
                    tail[k]++;
                end else begin
                    failNow($sformatf("dut%0d scoreboard overflow", k));
                end
                accepted[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int    idx;
        int    base;
        int    baseArr [NDUT];
        int    issued  [NDUT];
        bit    done;
        vec_t  hv [4];
        beat_t e;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            applyStimulus(k, 1'b0, '0, '0, 1'b0);
            outReady[k] = 1'b1;
            head[k]     = 0;
            tail[k]     = 0;
            popCnt[k]   = 0;
            accepted[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("dut%0d reset out_valid", k), outValid[k], 0);
            checkOutput($sformatf("dut%0d reset in_ready", k), inReady[k], 0);
            checkOutput($sformatf("dut%0d reset result", k), res[k], 0);
            checkOutput($sformatf("dut%0d reset flags", k),
                        {coutO[k], ovfO[k], zeroO[k]}, 0);
        end
        rst = 1'b0;

        // Directed table on every instance, with exact latency
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 10; i++) begin
                applyStimulus(k, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
                tick();
                checkOutput($sformatf("dut%0d vec%0d accept", k, i), accepted[k], 1);
                applyStimulus(k, 1'b0, '0, '0, 1'b0);
                for (int l = 1; l < stgOf[k]; l++) begin
                    checkOutput($sformatf("dut%0d vec%0d early out_valid", k, i), outValid[k], 0);
                    tick();
                end
                checkOutput($sformatf("dut%0d vec%0d out_valid", k, i), outValid[k], 1);
                checkOutput($sformatf("dut%0d vec%0d result", k, i), res[k], vecs[i].er);
                checkOutput($sformatf("dut%0d vec%0d cout", k, i), coutO[k], vecs[i].ec);
                checkOutput($sformatf("dut%0d vec%0d ovf", k, i), ovfO[k], vecs[i].eo);
                checkOutput($sformatf("dut%0d vec%0d zero", k, i), zeroO[k], vecs[i].ez);
            end
            tick();
        end

        // Stall: four beats offered into the 2-stage instance with the consumer blocked
        for (int i = 0; i < 4; i++) begin
            hv[i].a  = randOperand();
            hv[i].b  = randOperand();
            hv[i].op = 1'($urandom_range(1));
        end
        outReady[1] = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 4) applyStimulus(1, 1'b1, hv[idx].a, hv[idx].b, hv[idx].op);
            else         applyStimulus(1, 1'b0, '0, '0, 1'b0);
            tick();
            if (accepted[1]) idx++;
        end
        checkOutput("stall accepted count", 64'(idx), 2);
        checkOutput("stall in_ready", inReady[1], 0);
        e = refModel(hv[0].a, hv[0].b, hv[0].op);
        checkOutput("stall held result", res[1], e.result);
        outReady[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            base = popCnt[1];
            if (idx < 4) applyStimulus(1, 1'b1, hv[idx].a, hv[idx].b, hv[idx].op);
            else         applyStimulus(1, 1'b0, '0, '0, 1'b0);
            tick();
            if (accepted[1]) idx++;
            checkOutput($sformatf("drain beat %0d exits", c), 64'(popCnt[1] - base), 1);
        end
        applyStimulus(1, 1'b0, '0, '0, 1'b0);
        checkOutput("drain all accepted", 64'(idx), 4);

        // Reset mid-stream with two beats in flight
        outReady[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1'b1, randOperand(), randOperand(), 1'($urandom_range(1)));
            tick();
            checkOutput($sformatf("inflight beat %0d accept", i), accepted[1], 1);
        end
        rst = 1'b1;
        #1;
        checkOutput("midreset out_valid", outValid[1], 0);
        checkOutput("midreset result", res[1], 0);
        checkOutput("midreset flags", {coutO[1], ovfO[1], zeroO[1]}, 0);
        checkOutput("midreset in_ready", inReady[1], 0);
        for (int k = 0; k < NDUT; k++) head[k] = tail[k];
        tick();
        rst = 1'b0;
        outReady[1] = 1'b1;
        base = popCnt[1];
        applyStimulus(1, 1'b1, 32'h0000_0010, 32'h0000_0003, 1'b1);
        tick();
        checkOutput("first edge after reset accepts", accepted[1], 1);
        applyStimulus(1, 1'b0, '0, '0, 1'b0);
        repeat (6) tick();
        checkOutput("post-reset beats out", 64'(popCnt[1] - base), 1);

        // Random run on all instances with random back-pressure
        for (int k = 0; k < NDUT; k++) begin
            baseArr[k] = popCnt[k];
            issued[k]  = 0;
        end
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!inValid[k] || accepted[k]) begin
                    if (issued[k] < NRND && $urandom_range(3) != 0) begin
                        applyStimulus(k, 1'b1, randOperand(), randOperand(),
                                      1'($urandom_range(1)));
                        issued[k]++;
                    end else begin
                        applyStimulus(k, 1'b0, '0, '0, 1'b0);
                    end
                end
                outReady[k] = (issued[k] >= NRND) ? 1'b1 : ($urandom_range(2) != 0);
            end
            tick();
            done = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                if (popCnt[k] - baseArr[k] < NRND) done = 1'b0;
            end
        end
        if (!done) failNow("random run cycle budget expired");
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("dut%0d random beats out", k),
                        64'(popCnt[k] - baseArr[k]), 64'(NRND));
            checkOutput($sformatf("dut%0d scoreboard empty", k), 64'(tail[k] - head[k]), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; multiple of 4, minimum 8.
REQ-002 SHALL have parameter STAGES, default 2, pipeline register stages; range 1..WIDTH/4, and (WIDTH/4) divisible by STAGES.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result beat.
REQ-012 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 zero  output  1  result == 0.

Function
REQ-016 Subtract SHALL be computed as a + ~b with carry-in 1; add SHALL use carry-in 0.
REQ-017 The datapath SHALL be WIDTH/4 four-bit carry-lookahead groups; each stage SHALL resolve (WIDTH/4)/STAGES consecutive groups, LSB groups first, registering partial sums, the inter-group carry and the unprocessed operand bits.
REQ-018 Within a stage, the carry into each group SHALL be formed from group generate/propagate lookahead, not by ripple through bits.
REQ-019 A beat transfers in when in_valid && in_ready; it transfers out when out_valid && out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be one beat per cycle.
REQ-021 Each stage SHALL hold a valid bit; stage k SHALL load when stage k is empty or stage k advances in the same cycle (ready propagated combinationally from the output back).
REQ-022 in_ready SHALL equal (stage 0 empty) || (stage 0 advancing); it SHALL be 0 while rst is high.
REQ-023 While out_valid && !out_ready, result, cout, ovf and zero SHALL hold stable.
REQ-024 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 Simultaneous input and output transfer with a full pipeline SHALL be legal and SHALL keep the pipeline full.
REQ-026 ovf SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-027 zero SHALL be computed in the final stage from the full result.
REQ-028 Outputs SHALL be registered; no combinational path from a/b/op to result.

Reset
REQ-029 On rst assertion all stage valid bits SHALL clear immediately; out_valid = 0.
REQ-030 result, cout, ovf, zero and all pipeline data registers SHALL reset to 0.
REQ-031 Beats in flight at reset SHALL be discarded; no output SHALL appear for them after release.
REQ-032 The first rising edge after rst deassertion SHALL accept input if in_valid is high.

Structure
REQ-033 Shared package cla_pkg SHALL hold OP_ADD/OP_SUB encodings and the group width constant (4).
REQ-034 One sub-module, cla4_group (4-bit sum, group G/P, carry-in), SHALL be instantiated WIDTH/4 times via generate.

Verification (WIDTH=32, STAGES=2)
REQ-035 add 0xFFFFFFFF + 0x00000001, out_ready=1 -> 2 cycles later result 0x00000000, cout 1, ovf 0, zero 1.
REQ-036 sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cout 0, ovf 0, zero 0.
REQ-037 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf 1, cout 0; sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf 1, cout 1.
REQ-038 out_ready=0, issue 4 back-to-back beats -> in_ready drops after 2 accepted, outputs held stable; raise out_ready -> all beats exit in order, one per cycle.
REQ-039 rst pulsed mid-stream with 2 beats in flight -> out_valid 0 immediately, all outputs 0, no stale beat after release.
REQ-040 1000 random beats, random out_ready, STAGES in {1,2,8} -> every result matches a reference model, order preserved.
